multi_pulser: RTL and testbench

//  Parametrised successor to the single-button one-pulser: N push-button channels, each with a
//  2-flop synchroniser, counter-based debounce and a one-clock pulse on every debounced press.

---
 rtl/multi_pulser_pkg.sv | 29 ++
 rtl/multi_pulser_channel.sv | 125 ++++++++++++
 rtl/multi_pulser.sv | 33 +++
 tb/tb_multi_pulser.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_pulser_pkg.sv
// Shared definitions for the multi-channel push-button pulser: channel FSM
// states and the helpers that size the per-channel counters.
package multi_pulser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } pulser_state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Debounce counter must reach DEBOUNCE-1; never narrower than one bit.
    function automatic int cnt_width(input int debounce);
        int w;
        w = $clog2(debounce + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Repeat counter holds up to max(delay, period)-1 and is cleared at terminal count.
    function automatic int rcnt_width(input int delay, input int period);
        int w;
        w = $clog2(max_of(delay, period));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/multi_pulser_channel.sv
// One push-button channel: two-flop synchroniser, counter debounce and a
// press/auto-repeat FSM that emits a registered one-clock pulse.
module multi_pulser_channel
    import multi_pulser_pkg::*;
#(
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pb,
    input  logic repeat_en,
    output logic pulse,
    output logic held
);

    localparam int CNT_W  = cnt_width(DEBOUNCE);
    localparam int RCNT_W = rcnt_width(REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              held_q, held_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              pulse_q, pulse_d;
    pulser_state_e     state_q, state_d;
    logic              accept_rise;
    logic              accept_fall;

    // Synchronise the raw level and accept a new level only after it has held steady.
    always_comb begin
        s1_d        = pb;
        s2_d        = s1_q;
        held_d      = held_q;
        cnt_d       = '0;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        if (s2_q != held_q) begin
            if (cnt_q == CNT_LAST) begin
                held_d      = s2_q;
                accept_rise = s2_q;
                accept_fall = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Press FSM: pulse on acceptance, then optional hold-to-repeat pulses.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_rise) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (accept_fall) begin
                    rcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (repeat_en) begin
                    if (rcnt_q == DELAY_LAST) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_W'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (accept_fall) begin
                    rcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (repeat_en) begin
                    if (rcnt_q == PERIOD_LAST) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_W'(1);
                    end
                end
            end
            default: begin
                rcnt_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Channel state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            pulse_q <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
        end
    end

    assign pulse = pulse_q;
    assign held  = held_q;

endmodule

// File: rtl/multi_pulser.sv
// N independent push-button channels sharing clock, reset and the repeat mode.
module multi_pulser
    import multi_pulser_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] pb,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] held
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        multi_pulser_channel #(
            .DEBOUNCE      (DEBOUNCE),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .pb        (pb[i]),
            .repeat_en (repeat_en),
            .pulse     (pulse[i]),
            .held      (held[i])
        );
    end

endmodule

// File: tb/tb_multi_pulser.sv
// Randomised and scenario-driven bench for multi_pulser against a
// behavioural model of debounced presses and repeat timing.
module tb_multi_pulser;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int RD = 16;
    localparam int RP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] pb;
    logic          repeat_en;
    logic [CH-1:0] pulse;
    logic [CH-1:0] held;

    int checks   = 0;
    int failures = 0;
    int pulse_count[CH];

    // Model: a button level counts as seen two edges after it is sampled;
    // it is accepted once seen differing from the accepted level DB edges in a row.
    bit m_prev1[CH];
    bit m_prev2[CH];
    bit m_held[CH];
    bit m_pulse[CH];
    bit m_first[CH];
    int m_run[CH];
    int m_since[CH];

    multi_pulser #(
        .CHANNELS      (CH),
        .DEBOUNCE      (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pb        (pb),
        .repeat_en (repeat_en),
        .pulse     (pulse),
        .held      (held)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < CH; i++) begin
            m_prev1[i] = 0;
            m_prev2[i] = 0;
            m_held[i]  = 0;
            m_pulse[i] = 0;
            m_first[i] = 1;
            m_run[i]   = 0;
            m_since[i] = 0;
        end
    endtask

    // Pulses: one at acceptance, then after RD enabled held cycles, then every RP.
    task automatic modelStep(input logic [CH-1:0] pbv, input logic ren);
        for (int i = 0; i < CH; i++) begin
            bit seen;
            bit rose;
            seen       = m_prev2[i];
            m_prev2[i] = m_prev1[i];
            m_prev1[i] = pbv[i];
            rose       = 0;
            m_pulse[i] = 0;
            if (seen != m_held[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_held[i] = seen;
                    m_run[i]  = 0;
                    rose      = seen;
                end
            end else begin
                m_run[i] = 0;
            end
            if (rose) begin
                m_pulse[i] = 1;
                m_since[i] = 0;
                m_first[i] = 1;
            end else if (m_held[i] && ren) begin
                m_since[i]++;
                if (m_since[i] == (m_first[i] ? RD : RP)) begin
                    m_pulse[i] = 1;
                    m_since[i] = 0;
                    m_first[i] = 0;
                end
            end
        end
    endtask

    function automatic logic [CH-1:0] modelPulse();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_pulse[i];
        return v;
    endfunction

    function automatic logic [CH-1:0] modelHeld();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_held[i];
        return v;
    endfunction

    // One clock: check outputs mid-cycle, drive new inputs, advance the model at the edge.
    task automatic applyStimulus(input logic [CH-1:0] pbv, input logic ren, input logic rstv);
        @(negedge clk);
        checkOutput("pulse", 32'(pulse), 32'(modelPulse()));
        checkOutput("held", 32'(held), 32'(modelHeld()));
        for (int i = 0; i < CH; i++) if (pulse[i]) pulse_count[i]++;
        reset     = rstv;
        pb        = pbv;
        repeat_en = ren;
        @(posedge clk);
        if (!reset) modelReset();
        else modelStep(pbv, ren);
    endtask

    task automatic clearCounts();
        for (int i = 0; i < CH; i++) pulse_count[i] = 0;
    endtask

    initial begin
        logic [CH-1:0] cur;
        logic          ren;
        logic          rst;
        reset     = 1'b0;
        pb        = '1;
        repeat_en = 1'b0;
        modelReset();
        clearCounts();

        // Reset held with all buttons pressed, then release reset.
        for (int k = 0; k < 3; k++) applyStimulus('1, 1'b0, 1'b0);
        clearCounts();
        for (int k = 0; k < 14; k++) applyStimulus('1, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) applyStimulus('0, 1'b0, 1'b1);
        for (int i = 0; i < CH; i++) checkOutput($sformatf("rst_release_count%0d", i), pulse_count[i], 1);

        // Clean long press on ch0, no repeat.
        clearCounts();
        for (int k = 0; k < 40; k++) applyStimulus(4'b0001, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("single_press_count", pulse_count[0], 1);

        // Bounce on ch1 before settling high.
        clearCounts();
        applyStimulus(4'b0010, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0010, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) applyStimulus(4'b0010, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("bounce_count", pulse_count[1], 1);

        // Auto-repeat on ch2.
        clearCounts();
        for (int k = 0; k < 50; k++) applyStimulus(4'b0100, 1'b1, 1'b1);
        for (int k = 0; k < 14; k++) applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("repeat_count", pulse_count[2], 6);

        // Simultaneous press on ch0 and ch3.
        for (int k = 0; k < 10; k++) applyStimulus(4'b1001, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) applyStimulus(4'b0000, 1'b0, 1'b1);

        // Asynchronous reset while ch2 is repeating, then re-debounce.
        for (int k = 0; k < 30; k++) applyStimulus(4'b0100, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_pulse", 32'(pulse), 32'd0);
        checkOutput("async_rst_held", 32'(held), 32'd0);
        modelReset();
        for (int k = 0; k < 2; k++) applyStimulus(4'b0100, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) applyStimulus(4'b0100, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) applyStimulus(4'b0000, 1'b1, 1'b1);

        // Random button activity with occasional mode changes and resets.
        cur = '0;
        ren = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(9) == 0) cur[i] = ~cur[i];
            end
            if ($urandom_range(49) == 0) ren = ~ren;
            rst = ($urandom_range(799) == 0) ? 1'b0 : 1'b1;
            applyStimulus(cur, ren, rst);
        end
        for (int k = 0; k < 12; k++) applyStimulus('0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
